// File: rtl/uart_pkg.sv
// ============================================================================
// Module : uart_pkg
// Brief  : Shared UART types, constants and the clocks-per-bit helper.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } rx_state_t;

    // Rounded clocks-per-bit; the transmitter uses the same function.
    function automatic int calc_ticks(input int clock_hz, input int baud);
        return (clock_hz + baud / 2) / baud;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_if.sv
// ============================================================================
// Module : uart_rx_if
// Brief  : Receiver-to-consumer bundle: byte, done/error strobes and busy.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_rx_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] data;
    logic                 done;
    logic                 busy;
    logic                 error;

    modport master (output data, output done, output busy, output error);
    modport slave  (input  data, input  done, input  busy, input  error);
endinterface

`default_nettype wire

// File: rtl/uart_rx_bit_timer.sv
// ============================================================================
// Module : bit_timer
// Brief  : Loadable down-counter; strobes for one cycle as it expires.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_timer #(
    parameter int CNT_W = 4
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_load,
    input  wire logic [CNT_W-1:0] i_load_val,
    input  wire logic             i_en,
    output logic                  o_strobe
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_strobe = i_en && (r_cnt == CNT_W'(1));

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module : uart_rx
// Brief  : 8N1 UART receiver, LSB first; define UART_RX_PARITY_EN for 8E1.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx
    import uart_pkg::*;
#(
    parameter int CLOCK_HZ = 10_000_000,
    parameter int BAUD     = 115_200
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_rx,
    uart_rx_if.master rx_if
);

    localparam int TICKS = calc_ticks(CLOCK_HZ, BAUD);
    localparam int CNT_W = $clog2(TICKS + 1);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] c_load_half = CNT_W'(TICKS / 2);
    localparam logic [CNT_W-1:0] c_load_full = CNT_W'(TICKS);
    localparam logic [IDX_W-1:0] c_last_idx  = IDX_W'(DATA_BITS - 1);

    if (TICKS < 4) begin : g_ticks_check
        $error("uart_rx: CLOCK_HZ/BAUD gives fewer than 4 clocks per bit");
    end

    logic [1:0]           r_sync;
    logic                 r_prev;
    logic [2:0]           r_vld;
    logic                 w_rx;
    logic                 w_fall;
    rx_state_t            r_state;
    rx_state_t            w_next;
    logic                 w_load;
    logic [CNT_W-1:0]     w_load_val;
    logic                 w_busy;
    logic                 w_strobe;
    logic                 w_shift;
    logic                 w_done;
    logic                 w_error;
    logic [IDX_W-1:0]     r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_done;
    logic                 r_error;
`ifdef UART_RX_PARITY_EN
    logic                 w_par_chk;
    logic                 r_par_err;
`endif

    // r_vld holds off edge detection until the sync chain and r_prev carry real
    // line samples, so a line held low across reset is not seen as a start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b11;
            r_prev <= 1'b1;
            r_vld  <= 3'b000;
        end else begin
            r_sync <= {r_sync[0], i_rx};
            r_prev <= r_sync[1];
            r_vld  <= {r_vld[1:0], 1'b1};
        end
    end

    assign w_rx   = r_sync[1];
    assign w_fall = r_vld[2] & r_prev & ~w_rx;
    assign w_busy = (r_state == START) || (r_state == DATA) ||
                    (r_state == PARITY) || (r_state == STOP);

    bit_timer #(
        .CNT_W (CNT_W)
    ) u_bit_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_en       (w_busy),
        .o_strobe   (w_strobe)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (w_fall) w_next = START;
            START:     if (w_strobe) w_next = w_rx ? IDLE : DATA;
            DATA: begin
                if (w_strobe && (r_idx == c_last_idx)) begin
`ifdef UART_RX_PARITY_EN
                    w_next = PARITY;
`else
                    w_next = STOP;
`endif
                end
            end
            PARITY:    if (w_strobe) w_next = STOP;
            STOP:      if (w_strobe) w_next = w_rx ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (w_rx) w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_comb begin
        w_load     = 1'b0;
        w_load_val = c_load_full;
        w_shift    = 1'b0;
        w_done     = 1'b0;
        w_error    = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_chk  = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                w_load     = w_fall;
                w_load_val = c_load_half;
            end
            START:  w_load = w_strobe & ~w_rx;
            DATA: begin
                w_load  = w_strobe;
                w_shift = w_strobe;
            end
            PARITY: begin
                w_load = w_strobe;
`ifdef UART_RX_PARITY_EN
                w_par_chk = w_strobe;
`endif
            end
            STOP: begin
                if (w_strobe) begin
`ifdef UART_RX_PARITY_EN
                    w_done  = w_rx & ~r_par_err;
                    w_error = ~w_rx | r_par_err;
`else
                    w_done  = w_rx;
                    w_error = ~w_rx;
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_done  <= w_done;
            r_error <= w_error;
            if (r_state == IDLE) begin
                r_idx <= '0;
            end else if (w_shift) begin
                r_shift[r_idx] <= w_rx;
                r_idx          <= r_idx + IDX_W'(1);
            end
            if (w_done) begin
                r_data <= r_shift;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even parity: data ones plus the parity bit must total an even count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par_err <= 1'b0;
        end else if (r_state == IDLE) begin
            r_par_err <= 1'b0;
        end else if (w_par_chk) begin
            r_par_err <= (^r_shift) ^ w_rx;
        end
    end
`endif

    assign rx_if.data  = r_data;
    assign rx_if.done  = r_done;
    assign rx_if.busy  = w_busy;
    assign rx_if.error = r_error;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module : tb_uart_rx
// Brief  : Self-checking bench for uart_rx (TICKS = 10), table + random frames.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;

    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 100_000;
    localparam int TICKS  = (CLK_HZ + BAUD / 2) / BAUD;
`ifdef UART_RX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int LAT = 2 + TICKS / 2 + 9 * TICKS + 1 + PAR * TICKS;

    typedef struct {
        logic [7:0] d;
        bit         stop_ok;
        bit         pflip;
        bit         exp_done;
        bit         exp_err;
    } vec_t;

    logic clk;
    logic rst_n;
    logic rx;

    uart_rx_if u_if ();

    uart_rx #(
        .CLOCK_HZ (CLK_HZ),
        .BAUD     (BAUD)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .i_rx  (rx),
        .rx_if (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_done = 0;
    int n_err  = 0;
    int n_both = 0;
    int last_done_cyc = 0;
    logic [7:0] got_q[$];
    bit  meas = 0;
    bit  seen_busy = 0;
    int  run = 0;
    int  max_gap = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (u_if.done) begin
            n_done++;
            last_done_cyc = cyc;
            got_q.push_back(u_if.data);
        end
        if (u_if.error) n_err++;
        if (u_if.done && u_if.error) n_both++;
        if (meas) begin
            if (u_if.busy) begin
                if (seen_busy && run > max_gap) max_gap = run;
                run = 0;
                seen_busy = 1;
            end else if (seen_busy) begin
                run++;
            end
        end else begin
            run = 0;
            seen_busy = 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit pflip);
        rx = 1'b0;
        tick(TICKS);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick(TICKS);
        end
        if (PAR != 0) begin
            rx = (^d) ^ pflip;
            tick(TICKS);
        end
        rx = stop_ok;
        tick(TICKS);
    endtask

    initial begin
        vec_t       vecs[8];
        logic [7:0] hello[5];
        logic [7:0] last_good;
        int nd0, ne0, t0, spurious, lat;
        bit saw_busy;

        vecs[0] = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'h55, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'hAA, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{8'h07, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{8'h07, 1'b1, 1'b1, (PAR == 0), (PAR != 0)};
        vecs[6] = '{8'h80, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{8'h01, 1'b1, 1'b0, 1'b1, 1'b0};
        hello   = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};

        // Reset values
        rx    = 1'b1;
        rst_n = 1'b0;
        tick(3);
        check("reset_data",  {24'h0, u_if.data}, 32'h0);
        check("reset_done",  {31'h0, u_if.done}, 32'h0);
        check("reset_busy",  {31'h0, u_if.busy}, 32'h0);
        check("reset_error", {31'h0, u_if.error}, 32'h0);
        rst_n = 1'b1;
        tick(5);

        // Short low glitch: false start, then back to idle without strobes
        nd0 = n_done; ne0 = n_err; saw_busy = 0;
        rx = 1'b0;
        for (int i = 0; i < TICKS / 2 + 3; i++) begin
            if (i == 3) rx = 1'b1;
            tick(1);
            if (u_if.busy) saw_busy = 1;
        end
        check("glitch_saw_busy", {31'h0, saw_busy}, 32'h1);
        check("glitch_busy_idle", {31'h0, u_if.busy}, 32'h0);
        check("glitch_no_done", n_done - nd0, 0);
        check("glitch_no_error", n_err - ne0, 0);
        tick(5);

        // Bad stop bit, line held low, then a clean frame
        nd0 = n_done; ne0 = n_err; spurious = 0;
        send_frame(8'h55, 1'b0, 1'b0);
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (u_if.busy) spurious++;
        end
        rx = 1'b1;
        tick(4);
        check("badstop_error", n_err - ne0, 1);
        check("badstop_no_done", n_done - nd0, 0);
        check("badstop_data_kept", {24'h0, u_if.data}, 32'h0);
        check("badstop_no_spurious", spurious, 0);
        nd0 = n_done;
        send_frame(8'hA3, 1'b1, 1'b0);
        rx = 1'b1;
        tick(2);
        check("after_break_done", n_done - nd0, 1);
        check("after_break_data", {24'h0, u_if.data}, 32'hA3);

        // Latency of a single 'H'
        nd0 = n_done; ne0 = n_err;
        t0 = cyc;
        send_frame(8'h48, 1'b1, 1'b0);
        tick(3);
        lat = last_done_cyc - t0;
        check("h_done_once", n_done - nd0, 1);
        check("h_data", {24'h0, u_if.data}, 32'h48);
        check("h_no_error", n_err - ne0, 0);
        check($sformatf("h_latency_%0d_near_%0d", lat, LAT),
              {31'h0, (lat >= LAT - 2) && (lat <= LAT + 2)}, 32'h1);
        last_good = 8'h48;

        // Vector table
        for (int v = 0; v < 8; v++) begin
            nd0 = n_done; ne0 = n_err;
            send_frame(vecs[v].d, vecs[v].stop_ok, vecs[v].pflip);
            rx = 1'b1;
            tick(4);
            if (vecs[v].exp_done) last_good = vecs[v].d;
            check($sformatf("vec%0d_done", v), n_done - nd0, {31'h0, vecs[v].exp_done});
            check($sformatf("vec%0d_error", v), n_err - ne0, {31'h0, vecs[v].exp_err});
            check($sformatf("vec%0d_data", v), {24'h0, u_if.data}, {24'h0, last_good});
        end

        // "Hello" back to back with no idle time; busy drops only from the
        // stop-bit centre to the next start, about half a bit.
        got_q.delete();
        max_gap = 0;
        meas = 1;
        for (int k = 0; k < 5; k++) send_frame(hello[k], 1'b1, 1'b0);
        meas = 0;
        rx = 1'b1;
        tick(3);
        check("hello_count", got_q.size(), 5);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("hello_byte%0d", k),
                  (k < got_q.size()) ? {24'h0, got_q[k]} : 32'hFFFF_FFFF, {24'h0, hello[k]});
        end
        check($sformatf("hello_busy_gap_%0d_bounded", max_gap),
              {31'h0, max_gap <= TICKS / 2 + 3}, 32'h1);
        last_good = 8'h6F;

        // Random frames against the behavioural model
        for (int r = 0; r < 24; r++) begin
            logic [7:0] d;
            bit stop_ok, pflip, good;
            int gap;
            d       = 8'($urandom);
            stop_ok = ($urandom_range(0, 7) != 0);
            pflip   = ($urandom_range(0, 5) == 0);
            good    = stop_ok && !((PAR != 0) && pflip);
            gap     = stop_ok ? $urandom_range(0, 6) : $urandom_range(4, 8);
            nd0 = n_done; ne0 = n_err;
            send_frame(d, stop_ok, pflip);
            rx = 1'b1;
            tick(1);
            if (good) last_good = d;
            check($sformatf("rnd%0d_done", r), n_done - nd0, {31'h0, good});
            check($sformatf("rnd%0d_error", r), n_err - ne0, {31'h0, !good});
            check($sformatf("rnd%0d_data", r), {24'h0, u_if.data}, {24'h0, last_good});
            if (gap > 1) tick(gap - 1);
        end
        tick(4);

        // Reset asserted during bit 4 of 0xFF
        rx = 1'b0;
        tick(TICKS);
        rx = 1'b1;
        tick(4 * TICKS + TICKS / 2);
        rst_n = 1'b0;
        tick(1);
        check("midrst_data",  {24'h0, u_if.data}, 32'h0);
        check("midrst_done",  {31'h0, u_if.done}, 32'h0);
        check("midrst_busy",  {31'h0, u_if.busy}, 32'h0);
        check("midrst_error", {31'h0, u_if.error}, 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(5);
        nd0 = n_done; ne0 = n_err;
        send_frame(8'h0F, 1'b1, 1'b0);
        rx = 1'b1;
        tick(2);
        check("postrst_done", n_done - nd0, 1);
        check("postrst_data", {24'h0, u_if.data}, 32'h0F);
        check("postrst_no_error", n_err - ne0, 0);

        // Line low across reset release: no start until a fresh falling edge
        rst_n = 1'b0;
        rx    = 1'b0;
        tick(3);
        rst_n = 1'b1;
        spurious = 0;
        nd0 = n_done; ne0 = n_err;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (u_if.busy) spurious++;
        end
        rx = 1'b1;
        tick(5);
        check("lowrel_no_busy", spurious, 0);
        check("lowrel_no_error", n_err - ne0, 0);
        send_frame(8'h3C, 1'b1, 1'b0);
        rx = 1'b1;
        tick(2);
        check("lowrel_done", n_done - nd0, 1);
        check("lowrel_data", {24'h0, u_if.data}, 32'h3C);

        check("done_error_exclusive", n_both, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
